// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the nibble-serial adder controller.
// Optional subtract support is enabled by defining SERIAL_ADDER_SUB_EN.
package serial_adder_pkg;

   // Width of the time-shared ripple-carry slice.
   localparam int SLICE_W = 4;

   // Controller states: waiting for operands, adding nibbles, holding result.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Number of slice passes needed for an operand of the given width.
   function automatic int nibbles(input int width);
      return width / SLICE_W;
   endfunction

endpackage

// File: rtl/serial_adder_ctrl_slice.sv
// Purely combinational 4-bit ripple-carry adder slice.
// Kept generic so other serial datapaths can reuse it.
module adder4_slice
   import serial_adder_pkg::*;
(
   input  logic [SLICE_W-1:0] a,
   input  logic [SLICE_W-1:0] b,
   input  logic               ci,
   output logic [SLICE_W-1:0] s,
   output logic               co
);

   logic [SLICE_W:0] c;

   // Ripple the carry bit by bit through the slice.
   always_comb begin
      // NOTE: every variable written here gets a value on every pass, so no latch is inferred.
      c    = '0;
      s    = '0;
      c[0] = ci;
      for (int i = 0; i < SLICE_W; i++) begin
         s[i]   = a[i] ^ b[i] ^ c[i];
         c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
      end
   end

   assign co = c[SLICE_W];

endmodule

// File: rtl/serial_adder_ctrl.sv
// Nibble-serial WIDTH-bit adder controller: accepts operands over valid/ready,
// adds them one nibble per cycle (LSB first) through a single 4-bit slice and
// presents the result over valid/ready. WIDTH must be a multiple of 4 and >= 8.
// Define SERIAL_ADDER_SUB_EN to add the in_sub port (A - B when in_sub=1).
module serial_adder_ctrl
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             in_sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_ovf,
   output logic             busy
);

   localparam int NIB   = nibbles(WIDTH);
   localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;

   state_t               state, state_nxt;
   logic [WIDTH-1:0]     a_reg, b_reg, sum_reg;
   logic                 carry_reg, cout_reg, ovf_reg;
   logic [CNT_W-1:0]     cnt;
   logic [WIDTH-1:0]     b_in_eff;
   logic                 cin_in_eff;
   logic [SLICE_W-1:0]   slice_a, slice_b, slice_s;
   logic                 slice_co;
   logic                 last;

   // Operand B and carry-in as they will be latched at accept time.
`ifdef SERIAL_ADDER_SUB_EN
   assign b_in_eff   = in_sub ? ~in_b : in_b;
   assign cin_in_eff = in_sub ? 1'b1  : in_cin;
`else
   assign b_in_eff   = in_b;
   assign cin_in_eff = in_cin;
`endif

   assign last    = (cnt == CNT_W'(NIB - 1));
   assign slice_a = a_reg[int'(cnt) * SLICE_W +: SLICE_W];
   assign slice_b = b_reg[int'(cnt) * SLICE_W +: SLICE_W];

   adder4_slice u_slice (
      .a  (slice_a),
      .b  (slice_b),
      .ci (carry_reg),
      .s  (slice_s),
      .co (slice_co)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state decode: accept, count nibbles, wait for the consumer.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid)  state_nxt = RUN;
         RUN:     if (last)      state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default:                state_nxt = IDLE;
      endcase
   end

   // Handshake outputs decoded from the state register only.
   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
      busy      = (state != IDLE);
   end

   // Operand capture, nibble stepping and result assembly.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_reg     <= '0;
         b_reg     <= '0;
         sum_reg   <= '0;
         carry_reg <= 1'b0;
         cout_reg  <= 1'b0;
         ovf_reg   <= 1'b0;
         cnt       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_reg     <= in_a;
                  b_reg     <= b_in_eff;
                  carry_reg <= cin_in_eff;
                  cnt       <= '0;
               end
            end
            RUN: begin
               sum_reg   <= {slice_s, sum_reg[WIDTH-1:SLICE_W]};
               carry_reg <= slice_co;
               cnt       <= cnt + 1'b1;
               // The top nibble carries the sign bits used for overflow.
               if (last) begin
                  cout_reg <= slice_co;
                  ovf_reg  <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                              (slice_s[SLICE_W-1] != a_reg[WIDTH-1]);
               end
            end
            default: ;
         endcase
      end
   end

   assign out_sum  = sum_reg;
   assign out_cout = cout_reg;
   assign out_ovf  = ovf_reg;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=16): directed test-plan
// cases, asynchronous reset mid-operation and randomized transactions
// compared against an arithmetic reference model.
module tb_serial_adder_ctrl;

   localparam int W = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid, in_ready;
   logic [W-1:0]  in_a, in_b;
   logic          in_cin;
   logic          in_sub;
   logic          out_valid, out_ready;
   logic [W-1:0]  out_sum;
   logic          out_cout, out_ovf, busy;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   serial_adder_ctrl #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_cin    (in_cin),
`ifdef SERIAL_ADDER_SUB_EN
      .in_sub    (in_sub),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_cout  (out_cout),
      .out_ovf   (out_ovf),
      .busy      (busy)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
   endtask

   // Reference: plain integer arithmetic, {ovf, cout, sum}.
   function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic cin, input logic sub);
      int unsigned beff, ci, total;
      int          sa, sb, ssum;
      logic        ovf;
      beff  = sub ? ((~b) & 32'hFFFF) : b;
      ci    = sub ? 1 : cin;
      total = a + beff + ci;
      sa    = (a    >= 32768) ? int'(a)    - 65536 : int'(a);
      sb    = (beff >= 32768) ? int'(beff) - 65536 : int'(beff);
      ssum  = sa + sb + int'(ci);
      ovf   = (ssum > 32767) || (ssum < -32768);
      return {ovf, total[W], total[W-1:0]};
   endfunction

   // Wait (bounded) for in_ready, then present operands for one accepting edge.
   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic sub);
      int t = 0;
      @(negedge clk);
      while (!in_ready && t < 20) begin
         @(negedge clk);
         t++;
      end
      check("in_ready_wait", {31'd0, in_ready}, 32'd1);
      in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      check("busy_after_accept", {31'd0, busy}, 32'd1);
      check("in_ready_run", {31'd0, in_ready}, 32'd0);
   endtask

   // Count latency to out_valid, check result, apply backpressure, then release.
   task automatic collect(input string tag, input logic [W+1:0] exp, input int hold);
      int lat = 0;
      while (!out_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check({tag, "_latency"}, lat, 4);
      check({tag, "_sum"},  {16'd0, out_sum}, {16'd0, exp[W-1:0]});
      check({tag, "_cout"}, {31'd0, out_cout}, {31'd0, exp[W]});
      check({tag, "_ovf"},  {31'd0, out_ovf},  {31'd0, exp[W+1]});
      for (int i = 0; i < hold; i++) begin
         in_valid = i[0];
         in_a = W'($urandom); in_b = W'($urandom);
         @(negedge clk);
         check({tag, "_bp_valid"}, {31'd0, out_valid}, 32'd1);
         check({tag, "_bp_sum"},   {16'd0, out_sum}, {16'd0, exp[W-1:0]});
         check({tag, "_bp_ready"}, {31'd0, in_ready}, 32'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
      check({tag, "_ready_back"}, {31'd0, in_ready}, 32'd1);
   endtask

   task automatic txn(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic cin, input logic sub, input logic [W+1:0] exp, input int hold);
      send(a, b, cin, sub);
      collect(tag, exp, hold);
   endtask

   initial begin
      logic [W-1:0] ra, rb;
      logic         rc, rs;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_in_ready",  {31'd0, in_ready},  32'd1);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_busy",      {31'd0, busy},      32'd0);
      check("rst_sum",       {16'd0, out_sum},   32'd0);
      rst_n = 1'b1;

      // Directed cases with hand-derived expectations: {ovf, cout, sum}.
      txn("d_1234_4321", 16'h1234, 16'h4321, 1'b0, 1'b0, {1'b0, 1'b0, 16'h5555}, 0);
      txn("d_ffff_0001", 16'hFFFF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b1, 16'h0000}, 0);
      txn("d_7fff_0001", 16'h7FFF, 16'h0001, 1'b0, 1'b0, {1'b1, 1'b0, 16'h8000}, 0);
      txn("d_8000_8000", 16'h8000, 16'h8000, 1'b0, 1'b0, {1'b1, 1'b1, 16'h0000}, 0);
      txn("d_cin",       16'h00FF, 16'h0000, 1'b1, 1'b0, {1'b0, 1'b0, 16'h0100}, 0);
      txn("d_backpress", 16'hA5A5, 16'h1111, 1'b0, 1'b0, {1'b0, 1'b0, 16'hB6B6}, 5);

      // Asynchronous reset in RUN with cnt=2.
      send(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("midrun_in_ready",  {31'd0, in_ready},  32'd1);
      check("midrun_out_valid", {31'd0, out_valid}, 32'd0);
      check("midrun_busy",      {31'd0, busy},      32'd0);
      check("midrun_sum",       {16'd0, out_sum},   32'd0);
      check("midrun_cout",      {31'd0, out_cout},  32'd0);
      check("midrun_ovf",       {31'd0, out_ovf},   32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      txn("d_after_rst", 16'h0003, 16'h0004, 1'b0, 1'b0, {1'b0, 1'b0, 16'h0007}, 0);

`ifdef SERIAL_ADDER_SUB_EN
      txn("d_sub_5_7", 16'h0005, 16'h0007, 1'b1, 1'b1, {1'b0, 1'b0, 16'hFFFE}, 0);
      txn("d_sub_7_5", 16'h0007, 16'h0005, 1'b0, 1'b1, {1'b0, 1'b1, 16'h0002}, 0);
`endif

      // Randomized transactions against the reference model.
      for (int k = 0; k < 24; k++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         rc = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
         rs = 1'($urandom);
`else
         rs = 1'b0;
`endif
         txn("rnd", ra, rb, rc, rs, model(ra, rb, rc, rs), int'($urandom_range(0, 3)));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Nibble-serial wide adder controller. It accepts two WIDTH-bit operands over a valid/ready handshake and time-shares one 4-bit ripple-carry slice across WIDTH/4 cycles, least-significant nibble first. It registers the inter-nibble carry and assembles the result in a shift register. It sits between an operand producer and a result consumer wherever a full-width combinational adder is too costly.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of 4 and ≥ 8
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operand presented
- in_ready  out  1  block can accept operands
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- in_cin  in  1  carry-in to nibble 0
- in_sub  in  1  subtract request; present only with SERIAL_ADDER_SUB_EN
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_sum  out  WIDTH  result
- out_cout  out  1  carry out of MSB
- out_ovf  out  1  signed two's-complement overflow
- busy  out  1  high in RUN or DONE

## Operation
- NIBBLES = WIDTH/4. FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, latch in_a, in_b and the effective carry into registers, clear nibble counter cnt and go to RUN.
- RUN: the slice adds a_reg[4·cnt+3:4·cnt] + b_eff nibble + carry_reg. Each cycle:
  - the sum nibble shifts into sum_reg from the top;
  - carry_reg ← slice carry-out;
  - cnt increments.
- When cnt==NIBBLES-1, the FSM goes to DONE after that cycle's update.
- DONE: out_valid=1. out_sum, out_cout and out_ovf are held stable. On out_ready, go to IDLE.
- in_ready=0 in RUN and DONE. Operands are not pipelined or overlapped.
- out_ovf = (a_msb == b_eff_msb) && (sum_msb != a_msb).
- Unsigned WIDTH+1-bit arithmetic: {out_cout, out_sum} = in_a + b_eff + cin_eff.
- Reset values: in_ready=1, out_valid=0, busy=0, out_sum=0, out_cout=0, out_ovf=0, state=IDLE, cnt=0.
- Reset asserted mid-RUN or mid-DONE: the operation is discarded and all of the above reset values apply immediately (asynchronously).
- out_valid only falls after out_ready has been seen high in DONE. Consumer backpressure is unbounded.
- in_valid while busy is ignored. The producer must hold its operands until in_ready.

## Timing
- Operand accept at edge T0. RUN occupies cycles T0..T0+NIBBLES-1. out_valid rises after edge T0+NIBBLES.
- Latency is NIBBLES cycles; NIBBLES=4 for WIDTH=16.
- Result handshake at edge T1: in_ready=1 from T1. The earliest next accept is edge T1+1.
- Sustained throughput is 1 result per NIBBLES+2 cycles with out_ready tied high.
- Slice path is combinational within one cycle: 4-bit ripple only. Registered outputs, no combinational in→out paths.

## Configuration
- SERIAL_ADDER_SUB_EN defined:
  - in_sub port exists.
  - When in_sub=1 at accept: b_eff=~in_b, cin_eff=1, in_cin is ignored, and out_cout=1 means no borrow.
  - When in_sub=0: behaviour is identical to the undefined case.
- Undefined: no in_sub port; b_eff=in_b, cin_eff=in_cin.

## Structure
- Package serial_adder_pkg: state typedef (IDLE/RUN/DONE), SLICE_W=4 constant, NIBBLES derivation helper.
- Sub-module adder4_slice: purely combinational 4-bit ripple-carry slice with ports a[3:0], b[3:0], ci, s[3:0], co.
  - Instantiated once.
  - Reusable by other serial blocks.
- Top: FSM, counter, operand/result registers, overflow logic.

## Test plan
- WIDTH=16, 0x1234+0x4321, cin=0:
  - out_sum=0x5555, cout=0, ovf=0;
  - out_valid rises exactly 4 cycles after accept.
- 0xFFFF+0x0001, cin=0: sum=0x0000, cout=1, ovf=0. Also confirms carry propagates across all nibbles.
- 0x7FFF+0x0001: sum=0x8000, cout=0, ovf=1. Then 0x8000+0x8000: sum=0x0000, cout=1, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE.
  - out_valid and out_sum stay stable, in_ready stays 0.
  - in_valid pulses are ignored.
  - Accept resumes the cycle after out_ready.
- Deassert rst_n during RUN cnt=2:
  - all outputs go to reset values at once;
  - the next transaction 0x0003+0x0004 gives 0x0007.
- With SERIAL_ADDER_SUB_EN: in_sub=1, 0x0005−0x0007 → sum=0xFFFE, cout=0. Then 0x0007−0x0005 → 0x0002, cout=1.
